// File: rtl/disp_stage.sv
// disp_stage: in-order dispatch stage between decode and execute.
//
// Holds one decoded instruction in a dispatch slot and checks it against the
// writeback-tracking scoreboard for RAW hazards. When it issues, it allocates
// a scoreboard entry if the instruction writes a nonzero rd, and moves the
// instruction into the execute pipeline register. Both sides use valid/ready
// handshakes, so a stall on either side only back-pressures upstream.
//
// Optional feature macro: DISP_PERF_CNT_EN. When it is defined, two saturating
// 32-bit stall counters are built. When it is undefined, both perf ports are
// tied to 0.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   dec_valid / dec_ready    decode-side handshake
//   dec_rs1/2, dec_rs1/2_en  source register indices and their read enables
//   dec_rd, dec_rd_wen       destination register index and its write enable
//   dec_pl                   opaque payload
//   flush                    synchronous kill of the not-yet-issued slot instruction
//   sb_rs1/2, sb_rd          scoreboard query and allocate indices
//   sb_disp_en               scoreboard allocate strobe
//   sb_raw, sb_full          combinational scoreboard status inputs
//   ex_valid / ex_ready      execute-side handshake
//   ex_rd, ex_rd_wen,
//   ex_tracked, ex_pl        registered execute-stage instruction fields
//   perf_raw_stall,
//   perf_full_stall          stall-cycle counters
//
// Slot FSM:
//   state | meaning
//   EMPTY | no instruction waiting to issue
//   HELD  | slot holds a decoded instruction awaiting issue
module disp_stage #(
    parameter int REG_AW = 5,
    parameter int PL_W   = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs1_en,
    input  logic              dec_rs2_en,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rd_wen,
    input  logic [PL_W-1:0]   dec_pl,
    input  logic              flush,
    output logic [REG_AW-1:0] sb_rs1,
    output logic [REG_AW-1:0] sb_rs2,
    output logic [REG_AW-1:0] sb_rd,
    output logic              sb_disp_en,
    input  logic              sb_raw,
    input  logic              sb_full,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_wen,
    output logic              ex_tracked,
    output logic [PL_W-1:0]   ex_pl,
    output logic [31:0]       perf_raw_stall,
    output logic [31:0]       perf_full_stall
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} slot_state_t;

    slot_state_t       state_q, state_d;
    logic              slot_valid;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic              rs1_en_q, rs2_en_q, rd_wen_q;
    logic [PL_W-1:0]   pl_q;

    logic need_alloc, out_free, fire, accept;

    assign slot_valid = (state_q == HELD);
    // x0 is never allocated, so a zeroed unused source can never match an entry.
    assign need_alloc = rd_wen_q & (rd_q != '0);
    assign out_free   = ~ex_valid | ex_ready;
    assign fire       = slot_valid & ~flush & ~sb_raw & ~(need_alloc & sb_full) & out_free;
    assign dec_ready  = ~slot_valid | fire | flush;
    assign accept     = dec_valid & dec_ready;

    assign sb_rs1     = (slot_valid & rs1_en_q) ? rs1_q : '0;
    assign sb_rs2     = (slot_valid & rs2_en_q) ? rs2_q : '0;
    assign sb_rd      = slot_valid ? rd_q : '0;
    assign sb_disp_en = fire & need_alloc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = HELD;
            HELD:    if ((fire | flush) & ~accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs1_en_q <= 1'b0;
            rs2_en_q <= 1'b0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            pl_q     <= '0;
        end else if (accept) begin
            rs1_q    <= dec_rs1;
            rs2_q    <= dec_rs2;
            rs1_en_q <= dec_rs1_en;
            rs2_en_q <= dec_rs2_en;
            rd_q     <= dec_rd;
            rd_wen_q <= dec_rd_wen;
            pl_q     <= dec_pl;
        end
    end

    // The execute register is left alone by flush: its entry is already
    // allocated and must still write back to release it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            ex_rd_wen  <= 1'b0;
            ex_tracked <= 1'b0;
            ex_pl      <= '0;
        end else if (fire) begin
            ex_valid   <= 1'b1;
            ex_rd      <= rd_q;
            ex_rd_wen  <= rd_wen_q;
            ex_tracked <= need_alloc;
            ex_pl      <= pl_q;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end
    end

`ifdef DISP_PERF_CNT_EN
    logic [31:0] raw_cnt, full_cnt;
    logic        raw_stall, full_stall;

    // RAW takes priority; a stall due only to execute back-pressure is not counted.
    assign raw_stall  = slot_valid & ~flush & sb_raw;
    assign full_stall = slot_valid & ~flush & ~sb_raw & need_alloc & sb_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_cnt  <= '0;
            full_cnt <= '0;
        end else begin
            if (raw_stall && raw_cnt != 32'hFFFF_FFFF) raw_cnt <= raw_cnt + 32'd1;
            if (full_stall && full_cnt != 32'hFFFF_FFFF) full_cnt <= full_cnt + 32'd1;
        end
    end

    assign perf_raw_stall  = raw_cnt;
    assign perf_full_stall = full_cnt;
`else
    assign perf_raw_stall  = '0;
    assign perf_full_stall = '0;
`endif

endmodule

// File: tb/tb_disp_stage.sv
// Self-checking bench for disp_stage: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the slot and
// the execute register.
module tb_disp_stage;
    localparam int REG_AW = 5;
    localparam int PL_W   = 96;

    logic              clk = 1'b0;
    logic              rst;
    logic              dec_valid, dec_ready;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_rs1_en, dec_rs2_en, dec_rd_wen;
    logic [PL_W-1:0]   dec_pl;
    logic              flush;
    logic [REG_AW-1:0] sb_rs1, sb_rs2, sb_rd;
    logic              sb_disp_en, sb_raw, sb_full;
    logic              ex_valid, ex_ready, ex_rd_wen, ex_tracked;
    logic [REG_AW-1:0] ex_rd;
    logic [PL_W-1:0]   ex_pl;
    logic [31:0]       perf_raw_stall, perf_full_stall;

    always #5 clk = ~clk;

    disp_stage #(.REG_AW(REG_AW), .PL_W(PL_W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen), .dec_pl(dec_pl),
        .flush(flush),
        .sb_rs1(sb_rs1), .sb_rs2(sb_rs2), .sb_rd(sb_rd),
        .sb_disp_en(sb_disp_en), .sb_raw(sb_raw), .sb_full(sb_full),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_tracked(ex_tracked), .ex_pl(ex_pl),
        .perf_raw_stall(perf_raw_stall), .perf_full_stall(perf_full_stall)
    );

    typedef struct {
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic              rs1_en, rs2_en, rd_wen;
        logic [PL_W-1:0]   pl;
    } instr_t;

    typedef struct {
        instr_t ins;
        logic   tracked;
    } ex_t;

    instr_t m_slot[$];
    ex_t    m_ex[$];
    longint m_raw, m_full;
    int     checks, failures;
    int     seen_disp, seen_out;

    function automatic logic [31:0] perf_exp(longint v);
`ifdef DISP_PERF_CNT_EN
        if (v > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return v[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [REG_AW-1:0] rs1, bit e1, logic [REG_AW-1:0] rs2, bit e2,
                         logic [REG_AW-1:0] rd, bit w, logic [PL_W-1:0] pl);
        dec_valid  = v;
        dec_rs1    = rs1;
        dec_rs1_en = e1;
        dec_rs2    = rs2;
        dec_rs2_en = e2;
        dec_rd     = rd;
        dec_rd_wen = w;
        dec_pl     = pl;
    endtask

    // One clock cycle: compare DUT against the model at the falling edge,
    // advance the model, and return 1 time unit after the rising edge.
    task automatic step();
        instr_t s;
        instr_t n;
        ex_t    e;
        bit     have, alloc, issue, exp_rdy;
        @(negedge clk);
        have = (m_slot.size() > 0);
        if (have) s = m_slot[0];
        alloc   = have && s.rd_wen && (s.rd != 0);
        issue   = have && !flush && !sb_raw && !(alloc && sb_full) && (m_ex.size() == 0 || ex_ready);
        exp_rdy = !have || issue || flush;

        check("dec_ready", dec_ready, exp_rdy);
        check("sb_rs1", sb_rs1, (have && s.rs1_en) ? s.rs1 : 5'd0);
        check("sb_rs2", sb_rs2, (have && s.rs2_en) ? s.rs2 : 5'd0);
        if (have) check("sb_rd", sb_rd, s.rd);
        check("sb_disp_en", sb_disp_en, issue && alloc);
        check("ex_valid", ex_valid, m_ex.size() > 0);
        if (m_ex.size() > 0) begin
            check("ex_rd", ex_rd, m_ex[0].ins.rd);
            check("ex_rd_wen", ex_rd_wen, m_ex[0].ins.rd_wen);
            check("ex_tracked", ex_tracked, m_ex[0].tracked);
            check("ex_pl", ex_pl, m_ex[0].ins.pl);
        end
        check("perf_raw", perf_raw_stall, perf_exp(m_raw));
        check("perf_full", perf_full_stall, perf_exp(m_full));
        if (sb_disp_en) seen_disp++;
        if (ex_valid && ex_ready) seen_out++;

        if (have && !flush) begin
            if (sb_raw) m_raw++;
            else if (alloc && sb_full) m_full++;
        end
        if (m_ex.size() > 0 && ex_ready) void'(m_ex.pop_front());
        if (issue) begin
            e.ins = s;
            e.tracked = alloc;
            m_ex.push_back(e);
        end
        if (have && (issue || flush)) void'(m_slot.pop_front());
        if (dec_valid && exp_rdy) begin
            n.rs1 = dec_rs1; n.rs2 = dec_rs2; n.rd = dec_rd;
            n.rs1_en = dec_rs1_en; n.rs2_en = dec_rs2_en; n.rd_wen = dec_rd_wen;
            n.pl = dec_pl;
            m_slot.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; m_raw = 0; m_full = 0;
        rst = 1'b1; flush = 1'b0; sb_raw = 1'b0; sb_full = 1'b0; ex_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, '0);

        // Reset state
        @(posedge clk); #1;
        check("rst_dec_ready", dec_ready, 1'b1);
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_sb_disp_en", sb_disp_en, 1'b0);
        check("rst_sb_rs1", sb_rs1, 5'd0);
        check("rst_sb_rs2", sb_rs2, 5'd0);
        check("rst_sb_rd", sb_rd, 5'd0);
        check("rst_ex_rd", ex_rd, 5'd0);
        check("rst_ex_tracked", ex_tracked, 1'b0);
        check("rst_ex_pl", ex_pl, 96'd0);
        check("rst_perf_raw", perf_raw_stall, 32'd0);
        check("rst_perf_full", perf_full_stall, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Independent stream rd=1..4, sources x0
        seen_disp = 0; seen_out = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 1, 0, 1, 5'(i), 1, 96'(16'hA000 + i));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (3) step();
        check("stream_disp_count", seen_disp, 4);
        check("stream_out_count", seen_out, 4);

        // RAW stall for 3 cycles on rs1=5
        drive(1, 5, 1, 0, 0, 6, 1, 96'h5A5A);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        sb_raw = 1'b1;
        repeat (3) step();
        check("raw_perf_3", perf_raw_stall, perf_exp(3));
        sb_raw = 1'b0;
        step();
        step();
        check("raw_issued_pl", ex_pl, 96'h5A5A);

        // Unused rs2 and rd=x0 with rd_wen=1
        drive(1, 0, 0, 7, 0, 0, 1, 96'h0707);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        step();
        step();

        // Scoreboard full: allocating instruction stalls 2 cycles, non-writer fires
        drive(1, 0, 0, 0, 0, 3, 1, 96'hF0F0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        sb_full = 1'b1;
        repeat (2) step();
        check("full_perf_2", perf_full_stall, perf_exp(2));
        sb_full = 1'b0;
        step();
        drive(1, 0, 0, 0, 0, 3, 0, 96'hF1F1);
        sb_full = 1'b1;
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        step();
        check("full_nowen_fired", ex_pl, 96'hF1F1);
        sb_full = 1'b0;
        step();

        // Back-pressure from execute
        ex_ready = 1'b0;
        drive(1, 0, 0, 0, 0, 12, 1, 96'hE0E0);
        step();
        drive(1, 0, 0, 0, 0, 13, 1, 96'hF00F);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (3) step();
        check("bp_pl_stable", ex_pl, 96'hE0E0);
        check("bp_perf_raw", perf_raw_stall, perf_exp(3));
        check("bp_perf_full", perf_full_stall, perf_exp(2));
        ex_ready = 1'b1;
        step();
        step();
        check("bp_release_pl", ex_pl, 96'hF00F);

        // Flush plus accept while stalled on RAW
        drive(1, 5, 1, 0, 0, 9, 1, 96'hAAA);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        sb_raw = 1'b1;
        step();
        flush = 1'b1;
        drive(1, 0, 0, 0, 0, 10, 1, 96'hBBB);
        step();
        flush = 1'b0;
        sb_raw = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        step();
        step();
        check("flush_new_in_ex", ex_pl, 96'hBBB);
        step();

        // Asynchronous reset mid-stall with ex occupied
        ex_ready = 1'b0;
        drive(1, 0, 0, 0, 0, 11, 1, 96'hC0C0);
        step();
        drive(1, 5, 1, 0, 0, 14, 1, 96'hD0D0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        sb_raw = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check("arst_ex_valid", ex_valid, 1'b0);
        check("arst_dec_ready", dec_ready, 1'b1);
        check("arst_sb_rs1", sb_rs1, 5'd0);
        check("arst_sb_disp_en", sb_disp_en, 1'b0);
        check("arst_perf_raw", perf_raw_stall, 32'd0);
        m_slot.delete();
        m_ex.delete();
        m_raw = 0;
        m_full = 0;
        sb_raw = 1'b0;
        ex_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), {$urandom, $urandom, $urandom});
            sb_raw   = ($urandom_range(0, 3) == 0);
            sb_full  = ($urandom_range(0, 3) == 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
